mod_reduce_256: RTL and testbench
=================================

# mod_reduce_256

Word-serial modular reduction stage placed directly downstream of the 256-bit word-serial unsigned adder. Accepts the 257-bit sum as 16 × 16-bit words, least significant first, with the carry presented alongside the last word. Emits (sum mod p) as 16 words, using a single conditional subtraction of a preloaded 256-bit modulus p. Callers guarantee both adder operands are < p, so sum < 2p.

## Interface
- W, 16, word width in bits
- N, 16, words per operand (N·W = 256)

- clk  in  1  clock; all state changes on the rising edge
- clr_n  in  1  synchronous active-low reset
- p_we  in  1  modulus word write strobe
- p_in  in  W  modulus word, LSW first
- s_valid  in  1  sum word valid
- s_word  in  W  sum word, LSW first
- s_carry  in  1  adder carry-out, sampled only with word N-1
- s_ready  out  1  stage accepts a sum word this cycle
- r_valid  out  1  result word valid
- r_word  out  W  result word, LSW first
- r_last  out  1  marks result word N-1
- r_ready  in  1  downstream accepts the result word
- r_sub  out  1  1 = p was subtracted for the current result (stable in OUT)
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD, DECIDE, OUT.
- Modulus load:
  - p_we is honoured only in IDLE, and only on cycles with no sum-word transfer (the transfer has priority; p_we is dropped that cycle).
  - Each accepted write stores p_in at p_ptr (4-bit), then increments p_ptr, wrapping 15→0.
  - p_we outside IDLE is ignored.
- Sum transfer: occurs when s_valid & s_ready. s_ready = 1 in IDLE and LOAD, 0 otherwise.
- IDLE→LOAD on the first transfer. That word is index 0.
- LOAD, per transferred word i:
  - Store s_word into sum buffer S[i].
  - Compute D[i] = s_word − p[i] − bw, with 1-bit borrow register bw cleared on word 0. Store D[i] and the updated bw.
- After word N-1 is transferred, latch s_carry and go to DECIDE.
- DECIDE (1 cycle):
  - sub = s_carry | ~bw_final. This equals (257-bit sum ≥ p).
  - r_sub ← sub; output index ← 0; go to OUT.
- OUT:
  - r_valid = 1, r_word = sub ? D[idx] : S[idx], r_last = (idx == N-1).
  - idx advances on r_valid & r_ready.
  - Transfer with r_last → IDLE.
- Arithmetic: all modulo 2^16 per word. The result fits in 256 bits because sum < 2p. Behaviour for sum ≥ 2p is unspecified and not checked.
- No sum words are accepted during DECIDE or OUT. Upstream must hold.

## Timing
- Reset (clr_n = 0 at an edge) sets:
  - State IDLE; p_ptr = 0; p storage = 0; bw = 0; word counters = 0.
  - r_valid = 0, r_word = 0, r_last = 0, r_sub = 0, busy = 0.
  - s_ready = 1 from the first cycle after reset.
- Reset has priority over every other input, in any state, including mid-LOAD and mid-OUT. A partial operand is discarded and p must be reloaded.
- Latency: word N-1 transferred at edge T → DECIDE during cycle T..T+1 → r_valid = 1 and r_word = result word 0 after edge T+1.
- Best-case result stream is 16 consecutive cycles when r_ready stays 1.
- Backpressure: while r_ready = 0, r_word, r_last and r_valid hold steady. No word is skipped or repeated.
- Gaps in s_valid during LOAD are allowed. Word indices advance only on transfers.
- Throughput: back-to-back operands are allowed. The next operand's word 0 may transfer on the first IDLE cycle after the last result transfer.
- busy is high from the edge that accepts sum word 0 until the edge that accepts the r_last transfer.

## Test plan
In all scenarios, p = 2^256 − 2^32 − 977 (secp256k1 prime; words FC2F, FFFF, FFFE, FFFF ×13) is loaded in 16 p_we cycles after reset.

1. Sum = 5, carry 0 → result = 5 (word0 = 0x0005, rest 0), r_sub = 0. r_valid rises 2 edges after the last sum word.
2. Sum = p, carry 0 → result = 0 on all 16 words, r_sub = 1.
3. Sum = p − 1, carry 0 → result = p − 1 (word0 = 0xFC2E), r_sub = 0.
4. Sum = 2^256 + 5 (all words 0 except word0 = 0x0005, carry = 1) → result word0 = 0x03D6, word1 = 0x0000, word2 = 0x0001, rest 0; r_sub = 1.
5. Pulse reset after 7 sum words, then reload p and send sum = p + 0x1234 (carry 0) → result word0 = 0x1234, rest 0, r_sub = 1. No stale words from before the reset appear.
6. Hold r_ready = 0 for 3 cycles at idx 4 in OUT, and drive s_valid and p_we high throughout → r_word holds at word 4. s_ready = 0 and the p_we writes are ignored: a following run of scenario 1 gives the same result.

Source files
------------

// File: rtl/mod_reduce_256.sv
// mod_reduce_256: word-serial reduction of a 257-bit sum modulo a preloaded
// 256-bit modulus p. The sum arrives LSW first. Each word is stored both as it
// arrives and with p subtracted, rippling the borrow between words. Once the
// carry and the final borrow are known, a single decision selects which of the
// two stored copies is streamed out.
module mod_reduce_256 #(
    parameter int W = 16,
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         p_we,
    input  logic [W-1:0] p_in,
    input  logic         s_valid,
    input  logic [W-1:0] s_word,
    input  logic         s_carry,
    output logic         s_ready,
    output logic         r_valid,
    output logic [W-1:0] r_word,
    output logic         r_last,
    input  logic         r_ready,
    output logic         r_sub,
    output logic         busy
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DECIDE,
        OUT
    } state_t;

    state_t state;
    state_t next_state;

    logic [W-1:0]  p_mem [N];
    logic [W-1:0]  s_mem [N];
    logic [W-1:0]  d_mem [N];
    logic [IW-1:0] p_ptr;
    logic [IW-1:0] in_idx;
    logic [IW-1:0] out_idx;
    logic [IW-1:0] cur_idx;
    logic          bw;
    logic          carry_q;
    logic          borrow_in;
    logic          diff_borrow;
    logic [W-1:0]  diff;

    // The first word of an operand is taken in IDLE, so it always lands at
    // index 0 and starts the borrow chain from zero.
    assign cur_idx   = (state == LOAD) ? in_idx : '0;
    assign borrow_in = (state == LOAD) ? bw : 1'b0;
    assign {diff_borrow, diff} = {1'b0, s_word} - {1'b0, p_mem[cur_idx]}
                               - {{W{1'b0}}, borrow_in};

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and the handshake/result outputs.
    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        r_valid    = 1'b0;
        r_last     = 1'b0;
        r_word     = '0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && (in_idx == LAST_IDX)) begin
                    next_state = DECIDE;
                end
            end
            DECIDE: begin
                next_state = OUT;
            end
            OUT: begin
                r_valid = 1'b1;
                r_last  = (out_idx == LAST_IDX);
                r_word  = r_sub ? d_mem[out_idx] : s_mem[out_idx];
                if (r_ready && (out_idx == LAST_IDX)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Modulus storage, operand buffers, borrow chain and output index.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < N; i++) begin
                p_mem[i] <= '0;
            end
            p_ptr   <= '0;
            in_idx  <= '0;
            out_idx <= '0;
            bw      <= 1'b0;
            carry_q <= 1'b0;
            r_sub   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        s_mem[cur_idx] <= s_word;
                        d_mem[cur_idx] <= diff;
                        bw             <= diff_borrow;
                        in_idx         <= IW'(1);
                    end else if (p_we) begin
                        p_mem[p_ptr] <= p_in;
                        p_ptr        <= p_ptr + 1'b1;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        s_mem[cur_idx] <= s_word;
                        d_mem[cur_idx] <= diff;
                        bw             <= diff_borrow;
                        if (in_idx == LAST_IDX) begin
                            carry_q <= s_carry;
                            in_idx  <= '0;
                        end else begin
                            in_idx <= in_idx + 1'b1;
                        end
                    end
                end
                DECIDE: begin
                    r_sub   <= carry_q | ~bw;
                    out_idx <= '0;
                end
                OUT: begin
                    if (r_ready) begin
                        out_idx <= (out_idx == LAST_IDX) ? '0 : out_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_256.sv
// tb_mod_reduce_256: drives fixed and random sums through mod_reduce_256 and
// checks every result word against a whole-number model of (sum mod p).
module tb_mod_reduce_256;

    localparam logic [255:0] P_SECP =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef struct packed {
        logic [15:0] word;
        logic        last;
        logic        sub;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        p_we;
    logic [15:0] p_in;
    logic        s_valid;
    logic [15:0] s_word;
    logic        s_carry;
    logic        s_ready;
    logic        r_valid;
    logic [15:0] r_word;
    logic        r_last;
    logic        r_ready;
    logic        r_sub;
    logic        busy;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           ready_mode;
    logic         manual_ready;
    logic         rand_ready = 1'b1;
    logic [255:0] model_p;
    exp_t         exp_q[$];

    mod_reduce_256 dut (
        .clk     (clk),
        .clr_n   (clr_n),
        .p_we    (p_we),
        .p_in    (p_in),
        .s_valid (s_valid),
        .s_word  (s_word),
        .s_carry (s_carry),
        .s_ready (s_ready),
        .r_valid (r_valid),
        .r_word  (r_word),
        .r_last  (r_last),
        .r_ready (r_ready),
        .r_sub   (r_sub),
        .busy    (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // New random downstream-ready value each cycle.
    always @(posedge clk) rand_ready <= ($urandom_range(0, 3) != 0);

    // Downstream ready: always on, random, or under scenario control.
    always_comb begin
        r_ready = 1'b1;
        if (ready_mode == 1) r_ready = rand_ready;
        else if (ready_mode == 2) r_ready = manual_ready;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Returns {sub, result}: the sum reduced once by p when it is at least p.
    function automatic logic [256:0] model_reduce(input logic [256:0] sum,
                                                  input logic [255:0] p);
        logic [256:0] diff;
        if (sum >= {1'b0, p}) begin
            diff = sum - {1'b0, p};
            return {1'b1, diff[255:0]};
        end
        return {1'b0, sum[255:0]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic push_expected(input logic [256:0] sum);
        logic [256:0] m;
        exp_t e;
        m = model_reduce(sum, model_p);
        for (int i = 0; i < 16; i++) begin
            e.word = m[16*i +: 16];
            e.last = (i == 15);
            e.sub  = m[256];
            exp_q.push_back(e);
        end
    endtask

    // Compare every presented result word against the head of the model queue.
    always @(negedge clk) begin
        if (clr_n && r_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_r_valid", 32'(r_word), 32'h0);
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_result: got r_valid 1, expected 0");
            end else begin
                checkOutput("r_word", 32'(r_word), 32'(exp_q[0].word));
                checkOutput("r_last", 32'(r_last), 32'(exp_q[0].last));
                checkOutput("r_sub", 32'(r_sub), 32'(exp_q[0].sub));
                checkOutput("s_ready_in_out", 32'(s_ready), 32'h0);
                checkOutput("busy_in_out", 32'(busy), 32'h1);
                if (r_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Send nwords of a sum, optionally with idle gaps; full operands enter the model.
    task automatic applyStimulus(input logic [256:0] sum, input int nwords, input bit gaps);
        int   i = 0;
        int   guard = 0;
        logic accepted;
        while (i < nwords && guard < 3000) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_word  = 16'($urandom);
            end else begin
                s_valid = 1'b1;
                s_word  = sum[16*i +: 16];
                s_carry = (i == 15) ? sum[256] : 1'($urandom_range(0, 1));
            end
            accepted = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (accepted) i++;
            guard++;
        end
        s_valid = 1'b0;
        if (i < nwords) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL send_timeout: got %0d words accepted, expected %0d", i, nwords);
        end else if (nwords == 16) begin
            push_expected(sum);
        end
    endtask

    task automatic load_p(input logic [255:0] p);
        for (int i = 0; i < 16; i++) begin
            p_we = 1'b1;
            p_in = p[16*i +: 16];
            @(posedge clk);
            #1;
        end
        p_we    = 1'b0;
        model_p = p;
    endtask

    task automatic do_reset();
        clr_n   = 1'b0;
        s_valid = 1'b0;
        p_we    = 1'b0;
        @(posedge clk);
        #1;
        clr_n   = 1'b1;
        model_p = '0;
        exp_q.delete();
        checkOutput("rst_r_valid", 32'(r_valid), 32'h0);
        checkOutput("rst_r_word", 32'(r_word), 32'h0);
        checkOutput("rst_r_last", 32'(r_last), 32'h0);
        checkOutput("rst_r_sub", 32'(r_sub), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'h1);
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((exp_q.size() != 0 || busy) && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("drain_pending", 32'(exp_q.size()), 32'h0);
        checkOutput("drain_busy", 32'(busy), 32'h0);
    endtask

    task automatic run_sum5();
        ready_mode = 0;
        applyStimulus(257'd5, 16, 1'b0);
        checkOutput("s1_decide_r_valid", 32'(r_valid), 32'h0);
        checkOutput("s1_decide_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("s1_latency_r_valid", 32'(r_valid), 32'h1);
        checkOutput("s1_word0", 32'(r_word), 32'h0005);
        checkOutput("s1_r_sub", 32'(r_sub), 32'h0);
        wait_drain();
    endtask

    // Global time limit.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [256:0] m;
        logic [256:0] sum;
        logic [255:0] a;
        logic [255:0] b;
        logic [255:0] pr;

        clr_n        = 1'b0;
        p_we         = 1'b0;
        p_in         = '0;
        s_valid      = 1'b0;
        s_word       = '0;
        s_carry      = 1'b0;
        ready_mode   = 0;
        manual_ready = 1'b1;
        model_p      = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Hand-computed values pinning the model.
        m = model_reduce(257'd5, P_SECP);
        checkOutput("model_5_res", m[31:0], 32'h5);
        checkOutput("model_5_sub", 32'(m[256]), 32'h0);
        m = model_reduce({1'b0, P_SECP}, P_SECP);
        checkOutput("model_p_res", 32'(|m[255:0]), 32'h0);
        checkOutput("model_p_sub", 32'(m[256]), 32'h1);
        m = model_reduce({1'b0, P_SECP} - 257'd1, P_SECP);
        checkOutput("model_pm1_w0", m[31:0], 32'hFFFFFC2E);
        m = model_reduce({1'b1, 256'd5}, P_SECP);
        checkOutput("model_2p256_lo", m[31:0], 32'h000003D6);
        checkOutput("model_2p256_mid", m[63:32], 32'h00000001);
        checkOutput("model_2p256_hi", 32'(|m[255:64]), 32'h0);
        checkOutput("model_2p256_sub", 32'(m[256]), 32'h1);
        m = model_reduce({1'b0, P_SECP} + 257'h1234, P_SECP);
        checkOutput("model_p1234_lo", m[31:0], 32'h1234);

        load_p(P_SECP);

        // Small sum, no subtraction, with latency check.
        run_sum5();

        // Sum equal to p, and p - 1, with input gaps.
        applyStimulus({1'b0, P_SECP}, 16, 1'b1);
        wait_drain();
        applyStimulus({1'b0, P_SECP} - 257'd1, 16, 1'b1);
        wait_drain();

        // Sum above 2^256 where the carry forces the subtraction.
        applyStimulus({1'b1, 256'd5}, 16, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("s4_word0", 32'(r_word), 32'h03D6);
        checkOutput("s4_r_sub", 32'(r_sub), 32'h1);
        wait_drain();

        // Reset mid-operand: partial words and the modulus are discarded.
        applyStimulus({1'b0, P_SECP}, 7, 1'b1);
        do_reset();
        applyStimulus(257'd5, 16, 1'b0);
        wait_drain();
        load_p(P_SECP);
        applyStimulus({1'b0, P_SECP} + 257'h1234, 16, 1'b1);
        wait_drain();

        // Backpressure at word 4 while upstream and p_we push.
        ready_mode   = 2;
        manual_ready = 1'b1;
        applyStimulus({1'b0, 256'hABCD} << 64, 16, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        manual_ready = 1'b0;
        s_valid      = 1'b1;
        s_word       = 16'($urandom);
        p_we         = 1'b1;
        p_in         = 16'($urandom);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("s6_hold_word", 32'(r_word), 32'hABCD);
            checkOutput("s6_hold_valid", 32'(r_valid), 32'h1);
            checkOutput("s6_s_ready", 32'(s_ready), 32'h0);
        end
        s_valid      = 1'b0;
        p_we         = 1'b0;
        manual_ready = 1'b1;
        wait_drain();
        run_sum5();

        // Random back-to-back operands with random backpressure.
        ready_mode = 1;
        for (int k = 0; k < 20; k++) begin
            a = rand256();
            b = rand256();
            if (a >= model_p) a = a - model_p;
            if (b >= model_p) b = b - model_p;
            sum = {1'b0, a} + {1'b0, b};
            applyStimulus(sum, 16, ($urandom_range(0, 1) == 1));
        end
        wait_drain();

        // A random modulus; sixteen writes wrap p_ptr back to word 0.
        pr = rand256();
        pr[255] = 1'b1;
        load_p(pr);
        for (int k = 0; k < 10; k++) begin
            a = rand256();
            b = rand256();
            if (a >= model_p) a = a - model_p;
            if (b >= model_p) b = b - model_p;
            sum = {1'b0, a} + {1'b0, b};
            applyStimulus(sum, 16, ($urandom_range(0, 1) == 1));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
